// File: rtl/ntt_operand_switch_pkg.sv
// ntt_pkg: constants shared by the Kyber NTT operand-switch slice.
//   MODE_NTT / MODE_INTT : values of the schedule-select bit
//   DATA_W               : default coefficient width
//   KYBER_N              : polynomial length of the Kyber ring
package ntt_pkg;

   localparam logic MODE_NTT  = 1'b0;
   localparam logic MODE_INTT = 1'b1;

   localparam int DATA_W  = 16;
   localparam int KYBER_N = 256;

endpackage : ntt_pkg

// File: rtl/ntt_operand_switch_if.sv
// ntt_operand_switch_if: pass-control and operand bus of the operand switch.
//   start/mode/stage  : pass control from the sequencer
//   in_valid/a/b      : operand streams from the coefficient memory
//   busy              : pass in progress
//   out_valid/c/done  : registered selected operand to the butterfly
// Modports: master drives control and operands, slave is the switch.
interface ntt_operand_switch_if
   import ntt_pkg::*;
#(
   parameter int DATA_W = ntt_pkg::DATA_W,
   parameter int LOOP_W = 6
);

   localparam int STAGE_W = (LOOP_W > 1) ? $clog2(LOOP_W) : 1;

   logic               start;
   logic               mode;
   logic [STAGE_W-1:0] stage;
   logic               in_valid;
   logic [DATA_W-1:0]  a;
   logic [DATA_W-1:0]  b;
   logic               busy;
   logic               out_valid;
   logic [DATA_W-1:0]  c;
   logic               done;

   modport master (
      output start, mode, stage, in_valid, a, b,
      input  busy, out_valid, c, done
   );

   modport slave (
      input  start, mode, stage, in_valid, a, b,
      output busy, out_valid, c, done
   );

endinterface : ntt_operand_switch_if

// File: rtl/ntt_operand_switch_decode.sv
// ntt_switch_decode: combinational beat decoder of the operand switch.
//   beat   : index of the beat being accepted
//   mode   : latched schedule (NTT / INTT)
//   stage  : latched, already clamped, switch-bit index
//   enable : beat is past the zero-forced prefix
//   switch : 1 selects operand b, 0 selects operand a
module ntt_switch_decode
   import ntt_pkg::*;
#(
   parameter int LOOP_W      = 6,
   parameter int ENABLE_FROM = 26,
   parameter int STAGE_W     = (LOOP_W > 1) ? $clog2(LOOP_W) : 1
) (
   input  logic [LOOP_W-1:0]  beat,
   input  logic               mode,
   input  logic [STAGE_W-1:0] stage,
   output logic               enable,
   output logic               switch
);

   localparam int BEATS = 2 ** LOOP_W;

   // Constant thresholds are split out so no comparison degenerates
   // into an always-true / always-false unsigned compare.
   generate
      if (ENABLE_FROM <= 0) begin : g_en_all
         assign enable = 1'b1;
      end else if (ENABLE_FROM >= BEATS) begin : g_en_none
         assign enable = 1'b0;
      end else begin : g_en_cmp
         assign enable = (beat >= LOOP_W'(ENABLE_FROM));
      end
   endgenerate

   logic bit_s;

   // INTT takes b when the stage bit is set, NTT takes b when it is clear.
   always_comb begin
      bit_s  = beat[stage];
      switch = 1'b0;
      if (mode == MODE_INTT) begin
         switch = bit_s;
      end else begin
         switch = ~bit_s;
      end
   end

endmodule : ntt_switch_decode

// File: rtl/ntt_operand_switch.sv
// ntt_operand_switch: registered operand router between coefficient memory
// and butterfly unit. Owns the beat counter of a pass, latches schedule and
// stage on start, and emits one selected operand per accepted beat, one
// cycle later, behind out_valid.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ntt_operand_switch_if slave (control, operands, result)
module ntt_operand_switch
   import ntt_pkg::*;
#(
   parameter int DATA_W      = ntt_pkg::DATA_W,
   parameter int LOOP_W      = 6,
   parameter int ENABLE_FROM = 26
) (
   input logic                 clk,
   input logic                 rst,
   ntt_operand_switch_if.slave bus
);

   localparam int STAGE_W = (LOOP_W > 1) ? $clog2(LOOP_W) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]         state_r;
   logic [LOOP_W-1:0]  beat_r;
   logic               mode_r;
   logic [STAGE_W-1:0] stage_r;
   logic               out_valid_r;
   logic [DATA_W-1:0]  c_r;
   logic               done_r;

   logic               accept_s;
   logic               last_s;
   logic [STAGE_W-1:0] stage_clamp_s;
   logic               enable_s;
   logic               switch_s;
   logic [DATA_W-1:0]  c_next_s;

   // A start cycle never accepts a beat, even in RUN.
   always_comb begin
      accept_s = (state_r == ST_RUN) && bus.in_valid && !bus.start;
      last_s   = (beat_r == {LOOP_W{1'b1}});
   end

   // Out-of-range stage requests fall back to the top counter bit.
   always_comb begin
      stage_clamp_s = bus.stage;
      if (32'(bus.stage) >= 32'(LOOP_W)) begin
         stage_clamp_s = STAGE_W'(LOOP_W - 1);
      end else begin
         stage_clamp_s = bus.stage;
      end
   end

   ntt_switch_decode #(
      .LOOP_W      (LOOP_W),
      .ENABLE_FROM (ENABLE_FROM),
      .STAGE_W     (STAGE_W)
   ) u_decode (
      .beat   (beat_r),
      .mode   (mode_r),
      .stage  (stage_r),
      .enable (enable_s),
      .switch (switch_s)
   );

   // AND-OR operand mux; a disabled beat yields zero.
   always_comb begin
      c_next_s = (bus.a & {DATA_W{enable_s & ~switch_s}})
               | (bus.b & {DATA_W{enable_s &  switch_s}});
   end

   // Pass FSM, beat counter and start-time latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         beat_r  <= '0;
         mode_r  <= MODE_NTT;
         stage_r <= '0;
      end else if (bus.start) begin
         state_r <= ST_RUN;
         beat_r  <= '0;
         mode_r  <= bus.mode;
         stage_r <= stage_clamp_s;
      end else if (accept_s) begin
         if (last_s) begin
            state_r <= ST_IDLE;
            beat_r  <= '0;
         end else begin
            beat_r  <= beat_r + LOOP_W'(1);
         end
      end
   end

   // Output register: c only moves on an accept, so it holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         c_r         <= '0;
         done_r      <= 1'b0;
      end else begin
         out_valid_r <= accept_s;
         done_r      <= accept_s && last_s;
         if (accept_s) begin
            c_r <= c_next_s;
         end
      end
   end

   assign bus.busy      = state_r;
   assign bus.out_valid = out_valid_r;
   assign bus.c         = c_r;
   assign bus.done      = done_r;

endmodule : ntt_operand_switch
